clk_divider_prog: RTL and testbench

CLK_DIVIDER_PROG -- requirements
Module: clk_divider_prog

---
 rtl/clk_divider_prog.sv | 98 +++++++++
 tb/tb_clk_divider_prog.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/clk_divider_prog.sv
// Programmable multi-channel clock divider: each channel emits a 50% duty square
// wave of period 2*D with a toggle strobe, and accepts glitch-free divisor updates.
module clk_divider_prog #(
   parameter int CHANNELS    = 2,
   parameter int WIDTH       = 16,
   parameter int DEFAULT_DIV = 4,
   parameter int CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [CHANNELS-1:0] en,
   input  logic                sync,
   input  logic                cfg_valid,
   output logic                cfg_ready,
   input  logic [CH_W-1:0]     cfg_ch,
   input  logic [WIDTH-1:0]    cfg_div,
   output logic [CHANNELS-1:0] clk_out,
   output logic [CHANNELS-1:0] tick
);

   logic [WIDTH-1:0]    cnt      [CHANNELS];
   logic [WIDTH-1:0]    div      [CHANNELS];
   logic [WIDTH-1:0]    pend_div [CHANNELS];
   logic [CHANNELS-1:0] pend;
   logic [CHANNELS-1:0] xfer;
   logic [WIDTH-1:0]    new_div;

   // The update slot is busy only while the addressed channel still holds an
   // unapplied divisor; out-of-range indices are always accepted and dropped.
   always_comb begin
      cfg_ready = 1'b1;
      xfer      = '0;
      new_div   = (cfg_div == '0) ? WIDTH'(1) : cfg_div;
      for (int i = 0; i < CHANNELS; i++) begin
         if (cfg_ch == CH_W'(i) && pend[i]) begin
            cfg_ready = 1'b0;
         end
      end
      for (int i = 0; i < CHANNELS; i++) begin
         xfer[i] = cfg_valid && cfg_ready && (cfg_ch == CH_W'(i));
      end
   end

   // Divisor changes only land when the counter restarts at 0 (toggle, sync or
   // idle), so the counter can never sit above D-1 and never needs to wrap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend    <= '0;
         clk_out <= '0;
         tick    <= '0;
         for (int i = 0; i < CHANNELS; i++) begin
            cnt[i]      <= '0;
            div[i]      <= WIDTH'(DEFAULT_DIV);
            pend_div[i] <= '0;
         end
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            if (!en[i] || sync) begin
               cnt[i]     <= '0;
               clk_out[i] <= 1'b0;
               tick[i]    <= 1'b0;
               if (pend[i]) begin
                  div[i]  <= pend_div[i];
                  pend[i] <= 1'b0;
               end
               if (xfer[i]) begin
                  if (en[i]) begin
                     pend_div[i] <= new_div;
                     pend[i]     <= 1'b1;
                  end else begin
                     div[i] <= new_div;
                  end
               end
            end else if (cnt[i] >= div[i] - WIDTH'(1)) begin
               cnt[i]     <= '0;
               clk_out[i] <= ~clk_out[i];
               tick[i]    <= 1'b1;
               if (pend[i]) begin
                  div[i]  <= pend_div[i];
                  pend[i] <= 1'b0;
               end
               if (xfer[i]) begin
                  pend_div[i] <= new_div;
                  pend[i]     <= 1'b1;
               end
            end else begin
               cnt[i]  <= cnt[i] + WIDTH'(1);
               tick[i] <= 1'b0;
               if (xfer[i]) begin
                  pend_div[i] <= new_div;
                  pend[i]     <= 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_clk_divider_prog.sv
// Bench for clk_divider_prog: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a countdown-based reference model.
module tb_clk_divider_prog;

   localparam int NCH = 3;

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic [NCH-1:0] en = '0;
   logic           sync = 1'b0;
   logic           cfg_valid = 1'b0;
   logic           cfg_ready;
   logic [1:0]     cfg_ch = '0;
   logic [15:0]    cfg_div = '0;
   logic [NCH-1:0] clk_out;
   logic [NCH-1:0] tick;

   int checks = 0;
   int failures = 0;
   bit chk_on = 1'b0;

   int m_d    [NCH];
   int m_pd   [NCH];
   bit m_pend [NCH];
   int m_rem  [NCH];
   logic [NCH-1:0] m_out;
   logic [NCH-1:0] m_tick;

   clk_divider_prog #(.CHANNELS(NCH), .WIDTH(16), .DEFAULT_DIV(4)) dut (
      .clk(clk), .rst(rst), .en(en), .sync(sync),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
      .cfg_div(cfg_div), .clk_out(clk_out), .tick(tick)
   );

   always #5 clk = ~clk;

   task automatic check_output(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
      end
   endtask

   function automatic bit model_ready(input logic [1:0] ch);
      if (int'(ch) >= NCH) return 1'b1;
      return !m_pend[ch];
   endfunction

   // Each channel counts down the cycles left in its current half-period;
   // reaching zero flips the output and reloads from the (possibly new) divisor.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int c = 0; c < NCH; c++) begin
            m_d[c] = 4; m_pd[c] = 0; m_pend[c] = 0; m_rem[c] = 4;
         end
         m_out = '0;
         m_tick = '0;
      end else begin
         bit rdy;
         int nd;
         rdy = model_ready(cfg_ch);
         nd = (cfg_div == 0) ? 1 : int'(cfg_div);
         for (int c = 0; c < NCH; c++) begin
            bit xf;
            xf = cfg_valid && rdy && (int'(cfg_ch) == c);
            if (!en[c] || sync) begin
               m_out[c] = 1'b0;
               m_tick[c] = 1'b0;
               if (m_pend[c]) begin m_d[c] = m_pd[c]; m_pend[c] = 0; end
               if (xf) begin
                  if (en[c]) begin m_pd[c] = nd; m_pend[c] = 1; end
                  else m_d[c] = nd;
               end
               m_rem[c] = m_d[c];
            end else begin
               m_rem[c]--;
               if (m_rem[c] == 0) begin
                  m_out[c] = ~m_out[c];
                  m_tick[c] = 1'b1;
                  if (m_pend[c]) begin m_d[c] = m_pd[c]; m_pend[c] = 0; end
                  m_rem[c] = m_d[c];
               end else begin
                  m_tick[c] = 1'b0;
               end
               if (xf) begin m_pd[c] = nd; m_pend[c] = 1; end
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_on && !rst) begin
         check_output("clk_out", int'(clk_out), int'(m_out));
         check_output("tick", int'(tick), int'(m_tick));
         check_output("cfg_ready", int'(cfg_ready), int'(model_ready(cfg_ch)));
      end
   end

   task automatic next_cycle();
      @(negedge clk);
      #1;
   endtask

   task automatic apply_stimulus(input int ch, input int dv);
      int tries;
      cfg_ch = 2'(ch);
      cfg_div = 16'(dv);
      cfg_valid = 1'b1;
      tries = 0;
      #1;
      while (!cfg_ready && tries < 50) begin
         next_cycle();
         tries++;
      end
      if (tries >= 50) check_output("cfg_accept_timeout", tries, 0);
      next_cycle();
      cfg_valid = 1'b0;
   endtask

   task automatic measure_half(input int ch, input int expected, input string name);
      int n;
      n = 0;
      while (!tick[ch] && n < 100) begin next_cycle(); n++; end
      n = 0;
      do begin next_cycle(); n++; end while (!tick[ch] && n < 100);
      check_output(name, n, expected);
   endtask

   initial begin
      int n, f0, f1;
      #2 rst = 1'b1;
      #1;
      check_output("reset_clk_out", int'(clk_out), 0);
      check_output("reset_tick", int'(tick), 0);
      check_output("reset_ready", int'(cfg_ready), 1);
      next_cycle();
      next_cycle();
      rst = 1'b0;
      en = 3'b001;
      chk_on = 1'b1;

      measure_half(0, 4, "default_half0");
      measure_half(0, 4, "default_half1");
      check_output("idle_ch1_out", int'(clk_out[1]), 0);

      n = 0;
      while (!(tick[0] && clk_out[0]) && n < 20) begin next_cycle(); n++; end
      next_cycle();
      apply_stimulus(0, 2);
      check_output("pending_ready_low", int'(cfg_ready), 0);
      n = 0;
      do begin next_cycle(); n++; end while (!tick[0] && n < 20);
      check_output("current_half_kept", n, 2);
      check_output("ready_after_toggle", int'(cfg_ready), 1);
      n = 0;
      do begin next_cycle(); n++; end while (!tick[0] && n < 20);
      check_output("new_half_2", n, 2);

      apply_stimulus(1, 0);
      en = 3'b011;
      measure_half(1, 1, "zero_div_half");

      apply_stimulus(0, 3);
      apply_stimulus(1, 5);
      sync = 1'b1;
      next_cycle();
      sync = 1'b0;
      check_output("sync_out", int'(clk_out), 0);
      check_output("sync_tick", int'(tick), 0);
      f0 = 0; f1 = 0; n = 0;
      while ((f0 == 0 || f1 == 0) && n < 20) begin
         next_cycle();
         n++;
         if (clk_out[0] && f0 == 0) f0 = n;
         if (clk_out[1] && f1 == 0) f1 = n;
      end
      check_output("sync_rise_ch0", f0, 3);
      check_output("sync_rise_ch1", f1, 5);

      n = 0;
      while (!clk_out[0] && n < 20) begin next_cycle(); n++; end
      apply_stimulus(0, 7);
      #2 rst = 1'b1;
      #1;
      check_output("async_rst_out", int'(clk_out), 0);
      check_output("async_rst_ready", int'(cfg_ready), 1);
      next_cycle();
      next_cycle();
      rst = 1'b0;
      measure_half(0, 4, "post_rst_half");

      cfg_ch = 2'd3;
      cfg_div = 16'd1;
      cfg_valid = 1'b1;
      #1;
      check_output("out_of_range_ready", int'(cfg_ready), 1);
      next_cycle();
      cfg_valid = 1'b0;
      measure_half(0, 4, "discard_half_ch0");
      measure_half(1, 4, "discard_half_ch1");

      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(0, 49) == 0) en = 3'($urandom);
         sync = ($urandom_range(0, 39) == 0);
         cfg_valid = ($urandom_range(0, 2) == 0);
         cfg_ch = 2'($urandom_range(0, 3));
         cfg_div = 16'($urandom_range(0, 6));
         if ($urandom_range(0, 499) == 0) begin
            rst = 1'b1;
            next_cycle();
            rst = 1'b0;
         end
         next_cycle();
      end
      sync = 1'b0;
      cfg_valid = 1'b0;
      next_cycle();
      chk_on = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
